// File: rtl/fir_serial_mac.sv
// Serial N-tap FIR filter: one shared multiplier and accumulator step through all taps per sample.
// Latency: o_ce pulses NTAPS+3 cycles after the accepting edge; one sample per NTAPS+4 cycles at best.
// Backpressure: o_ready is high only in IDLE; samples and tap writes offered while it is low are dropped.
// Optional macro FIR_SATURATE_EN: clamp the result to the signed OW range instead of wrapping.
module fir_serial_mac #(
  parameter int IW    = 16,
  parameter int TW    = 16,
  parameter int NTAPS = 32,
  parameter int OW    = 16,
  parameter int SHIFT = 15,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_tap_wr,
  input  logic [AW-1:0] i_tap_addr,
  input  logic [TW-1:0] i_tap,
  input  logic          i_ce,
  output logic          o_ready,
  input  logic [IW-1:0] i_sample,
  output logic          o_ce,
  output logic [OW-1:0] o_result
);

  localparam int ACCW = IW + TW + AW;
  localparam int PW   = IW + TW;
  localparam int CW   = AW + 2;
  localparam int RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACCW:0] RND =
    (SHIFT > 0) ? ({{ACCW{1'b0}}, 1'b1} << RSH) : '0;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_MAC
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          ptr_q;
  logic [AW-1:0]          clr_idx_q;
  logic [AW-1:0]          tap_idx_q;
  logic [CW-1:0]          cnt_q;
  logic signed [IW-1:0]   x_rd_q;
  logic signed [TW-1:0]   h_rd_q;
  logic signed [PW-1:0]   prod_q;
  logic signed [PW-1:0]   prod_d;
  logic signed [ACCW-1:0] acc_q;
  logic                   o_ce_q;
  logic [OW-1:0]          o_result_q;

  logic signed [IW-1:0]   hist_q [NTAPS];
  logic signed [TW-1:0]   coef_q [NTAPS];

  logic                   ready;
  logic                   accept;
  logic                   mac_done;
  logic                   tap_wr_ok;
  logic                   rd_en;
  logic                   mul_en;
  logic                   acc_en;
  logic [AW-1:0]          rd_addr;

  logic signed [ACCW:0]   acc_ext;
  logic signed [ACCW:0]   rnd_sum;
  logic signed [ACCW:0]   res_full;
  logic [OW-1:0]          res_trunc;
  logic [ACCW:0]          res_sext;
  logic [OW-1:0]          res_fmt;

  // Next-state logic and per-cycle control strobes of the sequencer.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    accept   = 1'b0;
    mac_done = 1'b0;
    case (state_q)
      S_CLEAR: begin
        if (clr_idx_q == AW'(NTAPS - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        ready = 1'b1;
        if (i_ce && !i_reset) begin
          accept  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (cnt_q == CW'(NTAPS + 2)) begin
          mac_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Pipeline stage enables and circular history read address (newest sample minus tap index).
  always_comb begin
    tap_wr_ok = i_tap_wr && ready && !i_reset && ({1'b0, i_tap_addr} < (AW + 1)'(NTAPS));
    rd_en     = (state_q == S_MAC) && (cnt_q < CW'(NTAPS));
    mul_en    = (state_q == S_MAC) && (cnt_q >= CW'(1)) && (cnt_q <= CW'(NTAPS));
    acc_en    = (state_q == S_MAC) && (cnt_q >= CW'(2)) && (cnt_q <= CW'(NTAPS + 1));
    if (ptr_q >= tap_idx_q) rd_addr = ptr_q - tap_idx_q;
    else                    rd_addr = ptr_q + AW'(NTAPS) - tap_idx_q;
    prod_d = x_rd_q * h_rd_q;
  end

  // Round half up, shift, then reduce to OW bits by wrapping or clamping.
  always_comb begin
    acc_ext   = {acc_q[ACCW-1], acc_q};
    rnd_sum   = acc_ext + RND;
    res_full  = rnd_sum >>> SHIFT;
    res_trunc = res_full[OW-1:0];
    res_sext  = {{(ACCW + 1 - OW){res_trunc[OW-1]}}, res_trunc};
`ifdef FIR_SATURATE_EN
    if (res_sext != res_full) res_fmt = res_full[ACCW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    else                      res_fmt = res_trunc;
`else
    res_fmt = res_trunc;
`endif
  end

  // Control state, counters, accumulator and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      clr_idx_q  <= '0;
      tap_idx_q  <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      o_ce_q     <= 1'b0;
      o_result_q <= '0;
    end else begin
      state_q <= state_d;
      o_ce_q  <= mac_done;
      if (state_q == S_CLEAR) clr_idx_q <= clr_idx_q + AW'(1);
      if (accept) begin
        cnt_q     <= '0;
        tap_idx_q <= '0;
        acc_q     <= '0;
      end
      if (state_q == S_MAC) begin
        cnt_q <= cnt_q + CW'(1);
        if (rd_en)  tap_idx_q <= tap_idx_q + AW'(1);
        if (acc_en) acc_q <= acc_q + {{AW{prod_q[PW-1]}}, prod_q};
        if (mac_done) begin
          o_result_q <= res_fmt;
          ptr_q      <= (ptr_q == AW'(NTAPS - 1)) ? '0 : ptr_q + AW'(1);
        end
      end
    end
  end

  // Operand fetch and multiply register; contents are don't-care outside MAC.
  always_ff @(posedge i_clk) begin
    if (rd_en) begin
      x_rd_q <= hist_q[rd_addr];
      h_rd_q <= coef_q[tap_idx_q];
    end
    if (mul_en) prod_q <= prod_d;
  end

  // History buffer writes: zero fill during CLEAR, new sample on accept.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (state_q == S_CLEAR) hist_q[clr_idx_q] <= '0;
      else if (accept)        hist_q[ptr_q]     <= i_sample;
    end
  end

  // Coefficient RAM host writes, only while the block is idle.
  always_ff @(posedge i_clk) begin
    if (tap_wr_ok) coef_q[i_tap_addr] <= i_tap;
  end

  assign o_ready  = ready;
  assign o_ce     = o_ce_q;
  assign o_result = o_result_q;

endmodule
